// File: rtl/bus_arbiter2_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter2_if
//  Purpose  : Handshake and ownership signals between two requesters, the
//             shared memory write port and the bus_arbiter2 sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface bus_arbiter2_if;
    logic a_valid;
    logic a_last;
    logic a_ready;
    logic b_valid;
    logic b_last;
    logic b_ready;
    logic mem_valid;
    logic mem_last;
    logic mem_ready;
    logic sel;
    logic grant_a;
    logic grant_b;
    logic busy;

    // Requester/memory side: drives requests and memory acceptance.
    modport master (
        output a_valid, a_last, b_valid, b_last, mem_ready,
        input  a_ready, b_ready, mem_valid, mem_last, sel, grant_a, grant_b, busy
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_last, b_valid, b_last, mem_ready,
        output a_ready, b_ready, mem_valid, mem_last, sel, grant_a, grant_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter2
//  Purpose  : Two-requester round-robin arbiter for a shared 16-bit memory
//             write port; sequences valid/ready and burst ownership.
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter2 #(
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    bus_arbiter2_if.slave   bus
);

    localparam logic [7:0] c_beat_last = 8'(MAX_BURST - 1);
    localparam logic [7:0] c_idle_last = 8'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_sel;
    logic       r_grant_a;
    logic       r_grant_b;
    logic       r_last_grant;   // 0 = A was served last, 1 = B
    logic [7:0] r_beat_cnt;
    logic [7:0] r_idle_cnt;

    logic       w_owner_valid;
    logic       w_owner_last;
    logic       w_beat;
    logic       w_release;
    logic       w_a_ready;
    logic       w_b_ready;
    logic       w_mem_valid;
    logic       w_mem_last;

    // Owner pass-through; outputs are forced low while reset is sampled so
    // no beat can complete in the reset cycle.
    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_a_ready     = 1'b0;
        w_b_ready     = 1'b0;
        case (r_state)
            ST_GNT_A: begin
                w_owner_valid = bus.a_valid;
                w_owner_last  = bus.a_last;
                w_a_ready     = bus.mem_ready & ~reset;
            end
            ST_GNT_B: begin
                w_owner_valid = bus.b_valid;
                w_owner_last  = bus.b_last;
                w_b_ready     = bus.mem_ready & ~reset;
            end
            default: ;
        endcase
        w_mem_valid = w_owner_valid & ~reset;
        w_mem_last  = w_owner_last & ~reset;
        w_beat      = w_owner_valid & bus.mem_ready;
        w_release   = (r_state != ST_IDLE) &&
                      ((w_beat && (w_owner_last || r_beat_cnt == c_beat_last)) ||
                       (!w_owner_valid && r_idle_cnt == c_idle_last));
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.a_valid && (!bus.b_valid || r_last_grant))
                    w_next_state = ST_GNT_A;
                else if (bus.b_valid)
                    w_next_state = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (w_release)
                    w_next_state = bus.b_valid ? ST_GNT_B : ST_IDLE;
            end
            ST_GNT_B: begin
                if (w_release)
                    w_next_state = bus.a_valid ? ST_GNT_A : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_grant_a    <= 1'b0;
            r_grant_b    <= 1'b0;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= 8'd0;
            r_idle_cnt   <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_grant_a <= (w_next_state == ST_GNT_A);
            r_grant_b <= (w_next_state == ST_GNT_B);
            // sel keeps its last value through IDLE so the mux does not toggle needlessly
            if (w_next_state == ST_GNT_B)
                r_sel <= 1'b1;
            else if (w_next_state == ST_GNT_A)
                r_sel <= 1'b0;

            if (w_release) begin
                r_last_grant <= (r_state == ST_GNT_B);
                r_beat_cnt   <= 8'd0;
                r_idle_cnt   <= 8'd0;
            end else if (r_state == ST_IDLE) begin
                r_beat_cnt   <= 8'd0;
                r_idle_cnt   <= 8'd0;
            end else begin
                if (w_beat)
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                r_idle_cnt <= w_owner_valid ? 8'd0 : r_idle_cnt + 8'd1;
            end
        end
    end

    assign bus.a_ready   = w_a_ready;
    assign bus.b_ready   = w_b_ready;
    assign bus.mem_valid = w_mem_valid;
    assign bus.mem_last  = w_mem_last;
    assign bus.sel       = r_sel;
    assign bus.grant_a   = r_grant_a;
    assign bus.grant_b   = r_grant_b;
    assign bus.busy      = r_grant_a | r_grant_b;

endmodule
`default_nettype wire
